// File: rtl/hd44780_responder_if.sv
// Character-LCD bus between an HD44780 driver and a responder.
// Signals:
//   rs - register select (0 = instruction, 1 = data)
//   e  - enable strobe; the bus is latched on its falling edge
//   d  - 8-bit data bus
// Modports: master drives the bus (the LCD driver), slave observes it
// (the display responder).
interface hd44780_responder_if;
  logic       rs;
  logic       e;
  logic [7:0] d;

  modport master (output rs, output e, output d);
  modport slave  (input rs, input e, input d);
endinterface

// File: rtl/hd44780_responder.sv
// HD44780-compatible display responder. It latches rs/d on each falling
// edge of e, decodes instructions and data into a 2x16 DDRAM shadow,
// models the busy time of each transfer and flags transfers that arrive
// while the controller is still busy.
// Ports:
//   clock          - system clock, rising edge
//   internal_reset - synchronous active-high reset
//   lcd            - rs/e/d bus (slave modport)
//   rd_addr        - DDRAM read index (0-15 line 1, 16-31 line 2)
//   rd_data        - registered DDRAM[rd_addr]
//   busy           - high while the previous transfer executes
//   cursor         - address counter as a DDRAM index
//   display_on     - D bit of the last display-control instruction
//   entry_inc      - 1 = cursor increments after a data write
//   init_done      - sticky, set by function set with DL=1 and N=1
//   wr_strobe      - one-cycle pulse per accepted data write
//   protocol_error - sticky, set by a falling edge of e while busy
module hd44780_responder #(
  parameter int CLK_FREQ = 100000000,
  parameter int T_CMD    = CLK_FREQ / 25000,
  parameter int T_LONG   = CLK_FREQ / 100000 * 152
) (
  input  logic                 clock,
  input  logic                 internal_reset,
  hd44780_responder_if.slave   lcd,
  input  logic [4:0]           rd_addr,
  output logic [7:0]           rd_data,
  output logic                 busy,
  output logic [4:0]           cursor,
  output logic                 display_on,
  output logic                 entry_inc,
  output logic                 init_done,
  output logic                 wr_strobe,
  output logic                 protocol_error
);

  localparam int T_MAX = (T_LONG > T_CMD) ? T_LONG : T_CMD;
  localparam int CNT_W = $clog2(T_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CLEAR} state_t;

  state_t           state;
  logic             e_q;
  logic             cmd_rs;
  logic [7:0]       cmd_d;
  logic [CNT_W-1:0] busy_cnt;
  logic [4:0]       clr_idx;
  logic [7:0]       mem [32];

  logic             fall;
  logic             long_cmd;
  logic             mem_we;
  logic [4:0]       mem_waddr;
  logic [7:0]       mem_wdata;

  // The 5-bit index wraps naturally, so 15->16 models 0x0F->0x40 and
  // 31->0 / 0->31 model the wrap between the two lines.
  function automatic logic [4:0] step_idx(input logic [4:0] idx, input logic up);
    return up ? idx + 5'd1 : idx - 5'd1;
  endfunction

  assign fall     = e_q & ~lcd.e;
  assign busy     = (busy_cnt != '0);
  // Clear (0x01) and return home (0x02/0x03) take the long execution time.
  assign long_cmd = ~lcd.rs & (lcd.d[7:2] == 6'b0) & (lcd.d[1:0] != 2'b0);

  // DDRAM write port: data writes land at the cursor, the clear fill walks
  // clr_idx. Writes are suppressed during reset so a fill aborts cleanly.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cursor;
    mem_wdata = cmd_d;
    if (!internal_reset) begin
      if (state == S_EXEC && cmd_rs) begin
        mem_we = 1'b1;
      end else if (state == S_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx;
        mem_wdata = 8'h20;
      end
    end
  end

  // DDRAM contents survive reset, so this array has no reset branch.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clock) begin
    if (internal_reset) rd_data <= 8'h00;
    else                rd_data <= mem[rd_addr];
  end

  // Main controller: edge capture, busy timing, instruction decode and
  // the clear fill sequencer.
  always_ff @(posedge clock) begin
    if (internal_reset) begin
      state          <= S_IDLE;
      e_q            <= 1'b0;
      cmd_rs         <= 1'b0;
      cmd_d          <= 8'h00;
      busy_cnt       <= '0;
      clr_idx        <= 5'd0;
      cursor         <= 5'd0;
      display_on     <= 1'b0;
      entry_inc      <= 1'b1;
      init_done      <= 1'b0;
      wr_strobe      <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      e_q       <= lcd.e;
      wr_strobe <= 1'b0;
      if (busy) busy_cnt <= busy_cnt - 1'b1;

      // Only a quiet controller accepts a transfer; anything else is a
      // protocol violation and the transfer is dropped.
      if (fall) begin
        if (busy || state != S_IDLE) begin
          protocol_error <= 1'b1;
        end else begin
          cmd_rs   <= lcd.rs;
          cmd_d    <= lcd.d;
          busy_cnt <= long_cmd ? CNT_W'(T_LONG) : CNT_W'(T_CMD);
          state    <= S_EXEC;
        end
      end

      case (state)
        S_IDLE: ;
        S_EXEC: begin
          state <= S_IDLE;
          if (cmd_rs) begin
            cursor    <= step_idx(cursor, entry_inc);
            wr_strobe <= 1'b1;
          end else begin
            casez (cmd_d)
              8'b1???????: cursor <= {cmd_d[6], cmd_d[3:0]};
              8'b01??????: ;
              8'b001?????: if (cmd_d[4] && cmd_d[3]) init_done <= 1'b1;
              8'b0001????: if (!cmd_d[3]) cursor <= step_idx(cursor, cmd_d[2]);
              8'b00001???: display_on <= cmd_d[2];
              8'b000001??: entry_inc <= cmd_d[1];
              8'b0000001?: cursor <= 5'd0;
              8'b00000001: begin
                cursor    <= 5'd0;
                entry_inc <= 1'b1;
                clr_idx   <= 5'd0;
                state     <= S_CLEAR;
              end
              default: ;
            endcase
          end
        end
        S_CLEAR: begin
          clr_idx <= clr_idx + 5'd1;
          if (clr_idx == 5'd31) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hd44780_responder.sv
// Directed bench for hd44780_responder: init sequence, data writes,
// address wrap, entry/shift modes, protocol violation and reset during a
// clear fill. Short busy times keep the run small.
module tb_hd44780_responder;

  localparam int T_CMD  = 50;
  localparam int T_LONG = 200;

  logic       clock = 1'b0;
  logic       internal_reset = 1'b1;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data;
  logic       busy;
  logic [4:0] cursor;
  logic       display_on;
  logic       entry_inc;
  logic       init_done;
  logic       wr_strobe;
  logic       protocol_error;

  int checks = 0;
  int passed = 0;
  int strobe_count = 0;

  hd44780_responder_if lcd_bus ();

  hd44780_responder #(
    .T_CMD  (T_CMD),
    .T_LONG (T_LONG)
  ) dut (
    .clock          (clock),
    .internal_reset (internal_reset),
    .lcd            (lcd_bus.slave),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .busy           (busy),
    .cursor         (cursor),
    .display_on     (display_on),
    .entry_inc      (entry_inc),
    .init_done      (init_done),
    .wr_strobe      (wr_strobe),
    .protocol_error (protocol_error)
  );

  always #5 clock = ~clock;

  // Count write strobes away from the active edge.
  always @(negedge clock) begin
    if (wr_strobe === 1'b1) strobe_count++;
  end

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    else
      passed++;
  endtask

  // Pulse e for 3 cycles with rs/d, then count busy cycles until busy drops.
  // Entered and left #1 after a rising edge.
  task automatic apply_stimulus(input logic rs_v, input logic [7:0] d_v,
                                output int busy_cycles);
    lcd_bus.rs = rs_v;
    lcd_bus.d  = d_v;
    lcd_bus.e  = 1'b1;
    repeat (3) @(posedge clock);
    #1 lcd_bus.e = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < T_LONG + 40; i++) begin
      @(posedge clock);
      #1;
      if (busy) busy_cycles++;
      else if (busy_cycles > 0) break;
    end
  endtask

  task automatic read_mem(input logic [4:0] idx, output logic [7:0] val);
    rd_addr = idx;
    @(posedge clock);
    #1 val = rd_data;
  endtask

  // Send a transfer and require the given busy length.
  task automatic send(input string tag, input logic rs_v, input logic [7:0] d_v,
                      input int t_exp);
    int bc;
    apply_stimulus(rs_v, d_v, bc);
    check_output(tag, bc, t_exp);
  endtask

  initial begin
    logic [7:0] v;
    int         s0;
    int         bc;
    lcd_bus.rs = 1'b0;
    lcd_bus.e  = 1'b0;
    lcd_bus.d  = 8'h00;

    repeat (3) @(posedge clock);
    #1;
    check_output("reset busy", busy, 0);
    check_output("reset cursor", cursor, 0);
    check_output("reset display_on", display_on, 0);
    check_output("reset entry_inc", entry_inc, 1);
    check_output("reset init_done", init_done, 0);
    check_output("reset wr_strobe", wr_strobe, 0);
    check_output("reset protocol_error", protocol_error, 0);
    check_output("reset rd_data", rd_data, 0);
    internal_reset = 1'b0;
    @(posedge clock);
    #1;

    // Init sequence
    send("busy 0x30a", 1'b0, 8'h30, T_CMD);
    send("busy 0x30b", 1'b0, 8'h30, T_CMD);
    send("busy 0x30c", 1'b0, 8'h30, T_CMD);
    check_output("init_done before 0x38", init_done, 0);
    send("busy 0x38", 1'b0, 8'h38, T_CMD);
    check_output("init_done after 0x38", init_done, 1);
    send("busy 0x08", 1'b0, 8'h08, T_CMD);
    check_output("display_on after 0x08", display_on, 0);
    send("busy clear", 1'b0, 8'h01, T_LONG);
    send("busy 0x06", 1'b0, 8'h06, T_CMD);
    send("busy 0x0C", 1'b0, 8'h0C, T_CMD);
    check_output("display_on after 0x0C", display_on, 1);
    check_output("entry_inc after init", entry_inc, 1);
    check_output("cursor after init", cursor, 0);
    check_output("protocol_error after init", protocol_error, 0);
    for (int i = 0; i < 32; i++) begin
      read_mem(5'(i), v);
      check_output($sformatf("cleared ddram[%0d]", i), v, 8'h20);
    end

    // Data writes
    s0 = strobe_count;
    send("busy write 0x48", 1'b1, 8'h48, T_CMD);
    send("busy write 0x69", 1'b1, 8'h69, T_CMD);
    check_output("strobe pulses", strobe_count - s0, 2);
    check_output("cursor after 2 writes", cursor, 2);
    read_mem(5'd0, v); check_output("ddram[0]=0x48", v, 8'h48);
    read_mem(5'd1, v); check_output("ddram[1]=0x69", v, 8'h69);

    // Address mapping and wrap
    send("busy 0xCF", 1'b0, 8'hCF, T_CMD);
    check_output("cursor after 0xCF", cursor, 31);
    send("busy write 0x41", 1'b1, 8'h41, T_CMD);
    send("busy write 0x42", 1'b1, 8'h42, T_CMD);
    check_output("cursor wrap 31->1", cursor, 1);
    read_mem(5'd31, v); check_output("ddram[31]=0x41", v, 8'h41);
    read_mem(5'd0, v);  check_output("ddram[0]=0x42", v, 8'h42);
    send("busy 0x8F", 1'b0, 8'h8F, T_CMD);
    send("busy write 0x43", 1'b1, 8'h43, T_CMD);
    read_mem(5'd15, v); check_output("ddram[15]=0x43", v, 8'h43);
    check_output("cursor 15->16", cursor, 16);

    // Entry mode decrement and shift
    send("busy 0x80", 1'b0, 8'h80, T_CMD);
    send("busy 0x04", 1'b0, 8'h04, T_CMD);
    check_output("entry_inc after 0x04", entry_inc, 0);
    send("busy write 0x58", 1'b1, 8'h58, T_CMD);
    read_mem(5'd0, v); check_output("ddram[0]=0x58", v, 8'h58);
    check_output("cursor 0->31 decrement", cursor, 31);
    send("busy 0x14", 1'b0, 8'h14, T_CMD);
    check_output("cursor shift right 31->0", cursor, 0);
    send("busy 0x10", 1'b0, 8'h10, T_CMD);
    check_output("cursor shift left 0->31", cursor, 31);
    send("busy 0x18", 1'b0, 8'h18, T_CMD);
    check_output("cursor display shift no effect", cursor, 31);
    send("busy 0x14b", 1'b0, 8'h14, T_CMD);
    check_output("cursor shift right again", cursor, 0);
    send("busy 0xC5", 1'b0, 8'hC5, T_CMD);
    check_output("cursor after 0xC5", cursor, 21);
    send("busy home", 1'b0, 8'h02, T_LONG);
    check_output("cursor after home", cursor, 0);
    send("busy 0x06 restore", 1'b0, 8'h06, T_CMD);

    // Second edge while busy
    lcd_bus.rs = 1'b1;
    lcd_bus.d  = 8'h61;
    lcd_bus.e  = 1'b1;
    repeat (3) @(posedge clock);
    #1 lcd_bus.e = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    lcd_bus.d = 8'h5A;
    lcd_bus.e = 1'b1;
    repeat (3) @(posedge clock);
    #1 lcd_bus.e = 1'b0;
    for (int i = 0; i < T_LONG; i++) begin
      @(posedge clock);
      #1;
      if (!busy) break;
    end
    check_output("busy dropped after violation", busy, 0);
    check_output("protocol_error set", protocol_error, 1);
    repeat (10) @(posedge clock);
    #1;
    check_output("protocol_error sticky", protocol_error, 1);
    check_output("cursor after ignored transfer", cursor, 1);
    read_mem(5'd0, v); check_output("ddram[0]=0x61", v, 8'h61);
    read_mem(5'd1, v); check_output("ddram[1] untouched", v, 8'h69);

    // Reset during clear fill
    send("busy 0x8A", 1'b0, 8'h8A, T_CMD);
    send("busy write 0x77", 1'b1, 8'h77, T_CMD);
    lcd_bus.rs = 1'b0;
    lcd_bus.d  = 8'h01;
    lcd_bus.e  = 1'b1;
    repeat (3) @(posedge clock);
    #1 lcd_bus.e = 1'b0;
    repeat (12) @(posedge clock);
    #1 internal_reset = 1'b1;
    @(posedge clock);
    #1;
    check_output("busy after abort", busy, 0);
    check_output("cursor after abort", cursor, 0);
    check_output("protocol_error cleared by reset", protocol_error, 0);
    internal_reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      read_mem(5'(i), v);
      check_output($sformatf("partial fill ddram[%0d]", i), v, 8'h20);
    end
    read_mem(5'd10, v); check_output("ddram[10] kept", v, 8'h77);
    read_mem(5'd15, v); check_output("ddram[15] kept", v, 8'h43);
    read_mem(5'd31, v); check_output("ddram[31] kept", v, 8'h41);
    apply_stimulus(1'b1, 8'h4B, bc);
    check_output("busy write after reset", bc, T_CMD);
    read_mem(5'd0, v); check_output("ddram[0]=0x4B", v, 8'h4B);
    check_output("cursor after post-reset write", cursor, 1);
    check_output("protocol_error after post-reset write", protocol_error, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
